multicycle_ctrl: RTL and testbench

// Multi-cycle MIPS control FSM. Sequences IF/ID/EXE/MEM/WB for one instruction at a time.

---
 rtl/multicycle_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control FSM (IF/ID/EXE/MEM/WB/HALT).
// It runs one instruction at a time and talks to memory over a req/ack
// handshake (mem_rd/mem_wr, mem_ack). It also counts retired instructions.
// Inputs : clk, rst_n (async, active low), op, funct, zero, mem_ack
// Outputs: mem_rd, mem_wr, IRWre, PCWre, PCSrc, ExtSel1/ExtSel2, ALUSrcB,
//          ALUOp, RegDst, DBDataSrc, RegWre, illegal (sticky), halted,
//          state, retired
`timescale 1ns/1ps
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             IRWre,
  output logic             PCWre,
  output logic [1:0]       PCSrc,
  output logic             ExtSel1,
  output logic             ExtSel2,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             RegDst,
  output logic             DBDataSrc,
  output logic             RegWre,
  output logic             illegal,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;

  // opcode decode
  logic is_r, is_addu, is_subu, is_addiu, is_andi, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_halt, is_legal;
  logic [1:0] ext_op;
  logic [2:0] alu_op;

  assign is_r     = (op == 6'b000000);
  assign is_addu  = is_r && (funct == 6'b100001);
  assign is_subu  = is_r && (funct == 6'b100011);
  assign is_addiu = (op == 6'b001001);
  assign is_andi  = (op == 6'b001100);
  assign is_ori   = (op == 6'b001101);
  assign is_lui   = (op == 6'b001111);
  assign is_lw    = (op == 6'b100011);
  assign is_sw    = (op == 6'b101011);
  assign is_beq   = (op == 6'b000100);
  assign is_j     = (op == 6'b000010);
  assign is_halt  = (op == 6'b111111);
  assign is_legal = is_addu | is_subu | is_addiu | is_andi | is_ori | is_lui |
                    is_lw | is_sw | is_beq;

  always_comb begin
    ext_op = 2'b01;
    if (is_lui)                ext_op = 2'b00;
    else if (is_andi | is_ori) ext_op = 2'b10;
  end

  always_comb begin
    alu_op = 3'b000;
    if (is_subu | is_beq) alu_op = 3'b001;
    else if (is_andi)     alu_op = 3'b010;
    else if (is_ori)      alu_op = 3'b011;
    else if (is_lui)      alu_op = 3'b100;
  end

  // next state and ungated strobes
  logic       retire, set_illegal;
  logic       rd_d, wr_d, irw_d, pcw_d, srcb_d, dst_d, db_d, rw_d;
  logic [1:0] pcsrc_d, ext_d;
  logic [2:0] alu_d;

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    irw_d       = 1'b0;
    pcw_d       = 1'b0;
    srcb_d      = 1'b0;
    dst_d       = 1'b0;
    db_d        = 1'b0;
    rw_d        = 1'b0;
    pcsrc_d     = 2'b00;
    ext_d       = 2'b00;
    alu_d       = 3'b000;
    case (state_q)
      S_IF: begin
        ext_d = 2'b01;
        rd_d  = 1'b1;
        if (mem_ack) begin
          irw_d   = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        ext_d = ext_op;
        alu_d = alu_op;
        if (is_j) begin
          pcw_d   = 1'b1;
          pcsrc_d = 2'b10;
          retire  = 1'b1;
          state_d = S_IF;
        end else if (is_halt) begin
          retire  = 1'b1;
          state_d = S_HALT;
        end else if (!is_legal) begin
          set_illegal = 1'b1;
          pcw_d       = 1'b1;
          state_d     = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        ext_d  = ext_op;
        alu_d  = alu_op;
        srcb_d = !(is_r | is_beq);
        if (is_beq) begin
          pcw_d   = 1'b1;
          pcsrc_d = zero ? 2'b01 : 2'b00;
          retire  = 1'b1;
          state_d = S_IF;
        end else if (is_lw | is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        ext_d  = ext_op;
        alu_d  = alu_op;
        srcb_d = 1'b1;
        rd_d   = is_lw;
        wr_d   = is_sw;
        if (mem_ack) begin
          if (is_sw) begin
            pcw_d   = 1'b1;
            retire  = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        ext_d   = ext_op;
        alu_d   = alu_op;
        srcb_d  = !is_r;
        rw_d    = 1'b1;
        dst_d   = is_r;
        db_d    = is_lw;
        pcw_d   = 1'b1;
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (set_illegal) illegal_q <= 1'b1;
      if (retire)      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Outputs are forced low while rst_n is asserted; the reset state IF
  // would otherwise present a fetch request during reset.
  assign mem_rd    = rst_n & rd_d;
  assign mem_wr    = rst_n & wr_d;
  assign IRWre     = rst_n & irw_d;
  assign PCWre     = rst_n & pcw_d;
  assign PCSrc     = rst_n ? pcsrc_d : 2'b00;
  assign ExtSel1   = rst_n & ext_d[1];
  assign ExtSel2   = rst_n & ext_d[0];
  assign ALUSrcB   = rst_n & srcb_d;
  assign ALUOp     = rst_n ? alu_d : 3'b000;
  assign RegDst    = rst_n & dst_d;
  assign DBDataSrc = rst_n & db_d;
  assign RegWre    = rst_n & rw_d;
  assign illegal   = rst_n & illegal_q;
  assign halted    = rst_n & (state_q == S_HALT);
  assign state     = rst_n ? state_q : S_IF;
  assign retired   = rst_n ? retired_q : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench for multicycle_ctrl with hand-computed
// expected values. A narrow retired counter exposes the wrap-around.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    op, funct;
  logic          zero, mem_ack;
  logic          mem_rd, mem_wr, IRWre, PCWre, ExtSel1, ExtSel2, ALUSrcB;
  logic          RegDst, DBDataSrc, RegWre, illegal, halted;
  logic [1:0]    PCSrc;
  logic [2:0]    ALUOp, state;
  logic [CW-1:0] retired;
  logic [16:0]   all_o;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_rd(mem_rd), .mem_wr(mem_wr), .IRWre(IRWre),
    .PCWre(PCWre), .PCSrc(PCSrc), .ExtSel1(ExtSel1), .ExtSel2(ExtSel2),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst), .DBDataSrc(DBDataSrc),
    .RegWre(RegWre), .illegal(illegal), .halted(halted), .state(state),
    .retired(retired)
  );

  always #5 clk = ~clk;

  assign all_o = {mem_rd, mem_wr, IRWre, PCWre, PCSrc, ExtSel1, ExtSel2,
                  ALUSrcB, ALUOp, RegDst, DBDataSrc, RegWre, illegal, halted};

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // per-instruction observations
  int unsigned r_cycles, r_pcw, r_memrd, r_memwr, r_both;
  logic [31:0] r_trace;
  logic [15:0] r_ext, r_rw;
  logic [1:0]  r_pcsrc, r_ext_id;
  logic [2:0]  r_alu;
  logic        r_db, r_dst, r_srcb;
  logic [CW-1:0] exp_ret;

  // Runs one instruction from IF until the FSM returns to IF or enters HALT.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int unsigned waits);
    int unsigned mw;
    mw = 0;
    r_cycles = 0; r_pcw = 0; r_memrd = 0; r_memwr = 0; r_both = 0;
    r_trace = '0; r_ext = '0; r_rw = '0; r_pcsrc = '0; r_ext_id = '0;
    r_alu = '0; r_db = 1'b0; r_dst = 1'b0; r_srcb = 1'b0;
    op = o; funct = f; zero = z;
    do begin
      mem_ack = (state == 3'd3) ? (mw >= waits) : 1'b1;
      #1;
      r_trace = (r_trace << 3) | 32'(state);
      r_ext   = (r_ext << 2) | 16'({ExtSel1, ExtSel2});
      r_rw    = (r_rw << 1) | 16'(RegWre);
      if (PCWre) begin r_pcw++; r_pcsrc = PCSrc; end
      if (RegWre) begin r_db = DBDataSrc; r_dst = RegDst; end
      if (state == 3'd1) r_ext_id = {ExtSel1, ExtSel2};
      if (state == 3'd2) begin r_alu = ALUOp; r_srcb = ALUSrcB; end
      if (state == 3'd3) begin
        mw++;
        if (mem_rd) r_memrd++;
        if (mem_wr) r_memwr++;
      end
      if (mem_rd && mem_wr) r_both++;
      @(posedge clk); #1;
      r_cycles++;
    end while (state != 3'd0 && state != 3'd7 && r_cycles < 64);
    check("cycle_bound", r_cycles < 64, 1'b1);
    check("rd_wr_excl", r_both, 0);
    mem_ack = 1'b1;
  endtask

  initial begin
    logic [14:0] acc;
    rst_n = 1'b0; op = 6'b001101; funct = '0; zero = 1'b0; mem_ack = 1'b1;
    exp_ret = '0;
    #2;
    check("rst_outs", all_o, 0);
    check("rst_state", state, 0);
    check("rst_retired", retired, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // ori
    run_instr(6'b001101, 6'd0, 1'b0, 0);
    exp_ret++;
    check("ori_states", r_trace, 32'o0124);
    check("ori_ext", r_ext, 16'b01_10_10_10);
    check("ori_regwre", r_rw, 16'b0001);
    check("ori_alu", r_alu, 3'b011);
    check("ori_pcw", r_pcw, 1);
    check("ori_retired", retired, 1);

    // lui, then addiu
    run_instr(6'b001111, 6'd0, 1'b0, 0);
    exp_ret++;
    check("lui_ext", r_ext_id, 2'b00);
    check("lui_alu", r_alu, 3'b100);
    check("lui_srcb", r_srcb, 1'b1);
    run_instr(6'b001001, 6'd0, 1'b0, 0);
    exp_ret++;
    check("addiu_ext", r_ext_id, 2'b01);
    check("addiu_alu", r_alu, 3'b000);
    check("addiu_cyc", r_cycles, 4);

    // lw with three wait cycles in MEM
    run_instr(6'b100011, 6'd0, 1'b0, 3);
    exp_ret++;
    check("lw_cyc", r_cycles, 8);
    check("lw_memrd", r_memrd, 4);
    check("lw_db", r_db, 1'b1);
    check("lw_regwre", r_rw, 16'b0000_0001);
    check("lw_ret", retired, exp_ret);

    // beq taken / not taken
    run_instr(6'b000100, 6'd0, 1'b1, 0);
    exp_ret++;
    check("beq1_cyc", r_cycles, 3);
    check("beq1_pcsrc", r_pcsrc, 2'b01);
    check("beq1_rw", r_rw, 0);
    check("beq1_srcb", r_srcb, 1'b0);
    check("beq1_alu", r_alu, 3'b001);
    run_instr(6'b000100, 6'd0, 1'b0, 0);
    exp_ret++;
    check("beq0_cyc", r_cycles, 3);
    check("beq0_pcsrc", r_pcsrc, 2'b00);
    check("beq0_pcw", r_pcw, 1);

    // R-type addu / subu
    run_instr(6'b000000, 6'b100001, 1'b0, 0);
    exp_ret++;
    check("addu_cyc", r_cycles, 4);
    check("addu_dst", r_dst, 1'b1);
    check("addu_alu", r_alu, 3'b000);
    check("addu_srcb", r_srcb, 1'b0);
    run_instr(6'b000000, 6'b100011, 1'b0, 0);
    exp_ret++;
    check("subu_alu", r_alu, 3'b001);
    check("wrap", retired, 0);

    // sw and j
    run_instr(6'b101011, 6'd0, 1'b0, 0);
    exp_ret++;
    check("sw_cyc", r_cycles, 4);
    check("sw_memwr", r_memwr, 1);
    check("sw_pcw", r_pcw, 1);
    check("sw_rw", r_rw, 0);
    run_instr(6'b000010, 6'd0, 1'b0, 0);
    exp_ret++;
    check("j_cyc", r_cycles, 2);
    check("j_pcsrc", r_pcsrc, 2'b10);
    check("j_ret", retired, exp_ret);

    // illegal R-type funct, then illegal opcode
    check("illegal_pre", illegal, 1'b0);
    run_instr(6'b000000, 6'b000000, 1'b0, 0);
    check("badfn_ill", illegal, 1'b1);
    check("badfn_pcw", r_pcw, 1);
    check("badfn_ret", retired, exp_ret);
    run_instr(6'b010000, 6'd0, 1'b0, 0);
    check("badop_cyc", r_cycles, 2);
    check("badop_pcw", r_pcw, 1);
    check("badop_pcsrc", r_pcsrc, 2'b00);
    check("badop_ret", retired, exp_ret);

    // halt
    run_instr(6'b111111, 6'd0, 1'b0, 0);
    exp_ret++;
    check("halt_state", state, 3'd7);
    check("halted", halted, 1'b1);
    check("halt_ret", retired, exp_ret);
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      acc = acc | all_o[16:2];
    end
    check("halt_strobes", acc, 0);
    check("halt_stay", state, 3'd7);

    // reset out of HALT, then reset during MEM of sw
    rst_n = 1'b0; #1;
    check("rst2_outs", all_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; op = 6'b101011; mem_ack = 1'b1; #1;
    check("rst2_if", state, 0);
    check("rst2_fetch", mem_rd, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    check("sw_mem_state", state, 3'd3);
    check("sw_mem_wr", mem_wr, 1'b1);
    #2 rst_n = 1'b0; #1;
    check("async_wr", mem_wr, 1'b0);
    check("async_state", state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ack = 1'b1; #1;
    check("post_state", state, 0);
    check("post_ret", retired, 0);
    check("post_ill", illegal, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
